// File: rtl/uc_arbiter.sv
// rtl/uc_arbiter.sv - round-robin unit-clause arbiter with epoch history and conflict detection
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef VARIABLE_LENGTH
`define VARIABLE_LENGTH 8
`endif

module uc_arbiter #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int HIST_DEPTH = 8,
    parameter int LIT_W      = `VARIABLE_LENGTH,
    localparam int CNT_W     = $clog2(HIST_DEPTH) + 1,
    localparam int RR_W      = $clog2(NUM_ENGINE)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [LIT_W-1:0] uc_in [NUM_ENGINE],
    input  logic [NUM_ENGINE-1:0]   uc_valid_in,
    output logic [NUM_ENGINE-1:0]   uc_ready_out,
    input  logic                    flush_in,
    input  logic                    chosen_ready_in,
    output logic signed [LIT_W-1:0] chosen_uc_out,
    output logic                    chosen_uc_valid_out,
    output logic                    conflict_out,
    output logic                    hist_full_out,
    output logic [CNT_W-1:0]        dispatched_cnt_out
);

    typedef enum logic {S_RUN, S_CONFLICT} state_t;

    state_t                  state_q, state_d;
    logic [RR_W-1:0]         rr_q, rr_d;
    logic signed [LIT_W-1:0] cand_q, cand_d, out_q, out_d;
    logic                    cand_v_q, cand_v_d, out_v_q, out_v_d;
    logic signed [LIT_W-1:0] hist_q [HIST_DEPTH];
    logic signed [LIT_W-1:0] hist_d [HIST_DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic            match_eq, match_neg, cand_null, out_free, hist_room;
    logic            conflict_evt, move, slot_free, grant_v;
    logic [RR_W-1:0] grant_idx;

    assign hist_full_out       = (cnt_q == CNT_W'(HIST_DEPTH));
    assign dispatched_cnt_out  = cnt_q;
    assign chosen_uc_out       = out_q;
    assign chosen_uc_valid_out = out_v_q;

    // Candidate is compared against every dispatched literal of this epoch.
    always_comb begin
        match_eq  = 1'b0;
        match_neg = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                if (hist_q[i] == cand_q)  match_eq  = 1'b1;
                if (hist_q[i] == -cand_q) match_neg = 1'b1;
            end
        end
        if (out_v_q) begin
            if (out_q == cand_q)  match_eq  = 1'b1;
            if (out_q == -cand_q) match_neg = 1'b1;
        end
    end

    assign cand_null    = (cand_q == '0);
    assign out_free     = !out_v_q || chosen_ready_in;
    assign hist_room    = (cnt_q < CNT_W'(HIST_DEPTH));
    assign conflict_evt = cand_v_q && !cand_null && match_neg;
    assign move         = cand_v_q && !cand_null && !match_eq && !match_neg && out_free && hist_room;
    assign slot_free    = !cand_v_q || cand_null || match_eq || match_neg || move;

    always_comb begin : grant_comb
        int              j;
        logic [RR_W-1:0] idx;
        j            = 0;
        idx          = '0;
        grant_v      = 1'b0;
        grant_idx    = '0;
        uc_ready_out = '0;
        if (reset && state_q == S_RUN && !flush_in && !hist_full_out && slot_free) begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                j = int'(rr_q) + i;
                if (j >= NUM_ENGINE) j = j - NUM_ENGINE;
                idx = RR_W'(j);
                if (!grant_v && uc_valid_in[idx]) begin
                    grant_v   = 1'b1;
                    grant_idx = idx;
                end
            end
            if (grant_v) uc_ready_out[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d     = rr_q;
        cand_d   = cand_q;
        cand_v_d = cand_v_q;
        out_d    = out_q;
        out_v_d  = out_v_q;
        hist_d   = hist_q;
        cnt_d    = cnt_q;
        if (grant_v) begin
            if (int'(grant_idx) == NUM_ENGINE - 1) rr_d = '0;
            else                                   rr_d = grant_idx + 1'b1;
        end
        if (flush_in) begin
            cand_v_d = 1'b0;
            out_v_d  = 1'b0;
            cnt_d    = '0;
        end else begin
            if (grant_v) begin
                cand_d   = uc_in[grant_idx];
                cand_v_d = 1'b1;
            end else if (slot_free) begin
                cand_v_d = 1'b0;
            end
            if (move) begin
                out_d   = cand_q;
                out_v_d = 1'b1;
                for (int i = 0; i < HIST_DEPTH; i++) begin
                    if (CNT_W'(i) == cnt_q) hist_d[i] = cand_q;
                end
                cnt_d = cnt_q + 1'b1;
            end else if (chosen_ready_in) begin
                out_v_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:      if (!flush_in && conflict_evt) state_d = S_CONFLICT;
            S_CONFLICT: if (flush_in) state_d = S_RUN;
            default:    state_d = S_RUN;
        endcase
    end

    always_comb begin
        conflict_out = (state_q == S_CONFLICT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q     <= '0;
            cand_q   <= '0;
            cand_v_q <= 1'b0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            rr_q     <= rr_d;
            cand_q   <= cand_d;
            cand_v_q <= cand_v_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            cnt_q    <= cnt_d;
            hist_q   <= hist_d;
        end
    end

endmodule

// File: doc/uc_arbiter.md
# uc_arbiter

Collects unit-clause literals proposed by the `NUM_ENGINE` inference engines and selects them one at a time, round-robin. Each selection drives `chosen_uc_in`/`chosen_uc_valid_in` of `Distribution_unit`. The block keeps a history of literals dispatched in the current epoch: duplicates are suppressed, and a literal whose negation was already dispatched raises a sticky conflict. The conflict halts dispatch until the controller flushes.

## Interface
- `NUM_ENGINE`, default `` `NUM_ENGINE``: number of requesting engines; must be ≥2.
- `HIST_DEPTH`, default 8: number of history entries, i.e. the maximum number of literals dispatched per epoch.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `uc_in` input, `lit_t [NUM_ENGINE]`: proposed literals. `lit_t` is `` `VARIABLE_LENGTH``-bit two's complement; positive means true polarity, negative means negated, 0 means null.
- `uc_valid_in` input, `[NUM_ENGINE]`: proposal valid, one per engine.
- `uc_ready_out` output, `[NUM_ENGINE]`: one-hot grant. A proposal is consumed in a cycle where valid and ready are both high.
- `flush_in` input, 1 bit: starts a new epoch. Clears history, conflict, and all in-flight data.
- `chosen_ready_in` input, 1 bit: downstream can accept the chosen literal.
- `chosen_uc_out` output, `lit_t`: literal to `Distribution_unit`.
- `chosen_uc_valid_out` output, 1 bit: `chosen_uc_out` is valid.
- `conflict_out` output, 1 bit: sticky conflict flag, held until flush or reset.
- `hist_full_out` output, 1 bit: history holds `HIST_DEPTH` entries.
- `dispatched_cnt_out` output, `$clog2(HIST_DEPTH)+1` bits: number of valid history entries.

## Operation
- **State machine**, two states:
  - RUN → CONFLICT when the candidate conflicts with the history.
  - CONFLICT → RUN only on `flush_in`.
  - Reset puts the block in RUN.
- **Pipeline registers:**
  - Candidate register `cand`/`cand_v`.
  - Output register `chosen_uc_out`/`chosen_uc_valid_out`.
  - History array of `HIST_DEPTH` literals plus a count.
- **Grant**, combinational. Exactly one `uc_ready_out` bit is high, for the first valid engine at or after `rr_ptr` in circular order. Grant requires all of:
  - state is RUN;
  - `flush_in` is low;
  - `hist_full_out` is low;
  - the candidate slot is free, or is vacated this cycle.
- **Round-robin pointer:** on a grant to engine k, `rr_ptr` becomes (k+1) mod `NUM_ENGINE`. It is unchanged on flush.
- **Candidate resolution**, combinational on `cand`. Compare `cand` against every valid history entry and the output register:
  - **Null (0):** drop; slot vacates.
  - **Equal match (duplicate):** drop; slot vacates.
  - **Negated match (`h == -cand`):** drop; go to CONFLICT; slot vacates.
  - **New literal:** move to the output register and append to history. This happens only if the output register is empty or is being consumed this cycle (`chosen_ready_in` high); otherwise `cand` holds.
- **Output register:** stays valid until `chosen_ready_in` is high. It still drains in CONFLICT state; only new grants stop.
- **Flush:** on the next edge, clears `cand_v`, `chosen_uc_valid_out`, the history count, and conflict, and sets state to RUN. A proposal presented in the flush cycle is not granted.
- **Simultaneous events:**
  - A conflict and a move cannot occur in the same cycle, because there is only one candidate.
  - Flush has priority over everything.
- **History:**
  - Entries are never removed except by flush.
  - When the count reaches `HIST_DEPTH`, grants stop until flush. A candidate already in flight still resolves, and it may append only if the count is below `HIST_DEPTH`. The grant gating guarantees this.

## Timing
- **Reset values** (whenever `reset` is low):
  - `uc_ready_out` = 0.
  - `chosen_uc_out` = 0, `chosen_uc_valid_out` = 0.
  - `conflict_out` = 0, `hist_full_out` = 0, `dispatched_cnt_out` = 0.
  - `rr_ptr` = 0, `cand_v` = 0, state = RUN.
- **Latency:** a handshake at edge N loads `cand`. If the output register is free, `chosen_uc_valid_out` is high after edge N+1 (2 cycles).
- **Throughput:** one literal per cycle when `chosen_ready_in` is held high.
- **Conflict timing:** `conflict_out` rises after the edge that resolves the conflicting candidate. `uc_ready_out` is all-zero in the same cycle `conflict_out` is high.
- **Flush timing:** `dispatched_cnt_out` and `hist_full_out` update on the edge following the append or flush.
- **Reset mid-operation:** asynchronous clear; in-flight literals are lost.

## Test plan
- **Round-robin:** `NUM_ENGINE`=4; engines 0–3 each hold valid +1, +2, +3, +4 continuously, `chosen_ready_in`=1. Required: grants go 0,1,2,3 on consecutive cycles; outputs are +1,+2,+3,+4 starting 2 cycles after the first grant; count ends at 4.
- **Duplicate suppression:** engines 0 and 2 both propose +5. Required: both are granted, exactly one +5 is output, and `dispatched_cnt_out`=1.
- **Conflict:** dispatch +7, then engine 1 proposes -7. Required:
  - `conflict_out`=1 one cycle after the -7 grant;
  - -7 never appears on the output;
  - `uc_ready_out` stays 0 while another engine holds +9 valid.
  - After a flush pulse: `conflict_out`=0, count=0, and +9 is dispatched.
- **Backpressure:** `chosen_ready_in`=0 for 5 cycles while +3 and +4 are pending. Required: `chosen_uc_out` holds +3 stable, the candidate holds +4, and no further grants occur. When ready returns: +3, then +4 on consecutive cycles.
- **History full:** `HIST_DEPTH`=8; dispatch +1..+8. Required: `hist_full_out`=1, grants stop while +10 is valid, and flush restores grants.
- **Async reset:** assert `reset` low with a candidate and an output pending. Required: all outputs go 0 immediately, without waiting for a clock edge; after release, the first grant goes to engine 0.
